// File: rtl/bitwise_logic_seq_if.sv
// Operand/result handshake bundle for the chunked bitwise logic unit.
// master drives operands and out_ready; slave returns the result side.
interface bitwise_logic_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [1:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             is_zero;
    logic             busy;

    modport master (
        output in_valid, A, B, op, out_ready,
        input  in_ready, out_valid, result, is_zero, busy
    );

    modport slave (
        input  in_valid, A, B, op, out_ready,
        output in_ready, out_valid, result, is_zero, busy
    );
endinterface

// File: rtl/bitwise_logic_seq.sv
// Multi-cycle bitwise AND/OR/XOR/NOR unit that writes LANE result bits per cycle,
// lowest chunk first, between a valid/ready operand port and a valid/ready result port.
module bitwise_logic_seq #(
    parameter int WIDTH = 32,
    parameter int LANE  = 8
) (
    input  logic               clock,
    input  logic               reset,
    bitwise_logic_seq_if.slave bus
);
    localparam int N  = WIDTH / LANE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic [1:0]       op_reg, op_next;
    logic [WIDTH-1:0] result_reg, result_next;
    logic             is_zero_reg, is_zero_next;
    logic [WIDTH-1:0] run_result;
    logic             last_chunk;

    function automatic logic [LANE-1:0] lane_op(
        input logic [LANE-1:0] x,
        input logic [LANE-1:0] y,
        input logic [1:0]      sel
    );
        case (sel)
            2'b00:   lane_op = x & y;
            2'b01:   lane_op = x | y;
            2'b10:   lane_op = x ^ y;
            default: lane_op = ~(x | y);
        endcase
    endfunction

    // Only the chunk selected by the counter is recomputed; the rest hold.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_chunk
            localparam logic [CW-1:0] IDX = CW'(gi);
            assign run_result[gi*LANE +: LANE] = (cnt_reg == IDX)
                ? lane_op(a_reg[gi*LANE +: LANE], b_reg[gi*LANE +: LANE], op_reg)
                : result_reg[gi*LANE +: LANE];
        end
    endgenerate

    assign last_chunk = (cnt_reg == CW'(N - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            op_reg      <= '0;
            result_reg  <= '0;
            is_zero_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            a_reg       <= a_next;
            b_reg       <= b_next;
            op_reg      <= op_next;
            result_reg  <= result_next;
            is_zero_reg <= is_zero_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        a_next       = a_reg;
        b_next       = b_reg;
        op_next      = op_reg;
        result_next  = result_reg;
        is_zero_next = is_zero_reg;
        case (state_reg)
            IDLE: begin
                if (bus.in_valid) begin
                    a_next      = bus.A;
                    b_next      = bus.B;
                    op_next     = bus.op;
                    result_next = '0;
                    cnt_next    = '0;
                    state_next  = RUN;
                end
            end
            RUN: begin
                result_next = run_result;
                if (last_chunk) begin
                    cnt_next     = '0;
                    is_zero_next = (run_result == '0);
                    state_next   = DONE;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Handshake flags come from registered state; reset gates in_ready only.
    assign bus.in_ready  = (state_reg == IDLE) && !reset;
    assign bus.out_valid = (state_reg == DONE);
    assign bus.busy      = (state_reg == RUN) || (state_reg == DONE);
    assign bus.result    = result_reg;
    assign bus.is_zero   = is_zero_reg;
endmodule
